serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Bit-serial N-bit adder built around one 1-bit full-adder cell and a carry flip-flop.
//  Loads two operands on start, then adds one bit per clock, LSB first.
//  Registers the N-bit sum and carry-out, then pulses done.
//  Downstream consumer of the full-adder cell: sequences it over multi-bit words.
// PARAMETERS
//  WIDTH   4   operand/sum width in bits; legal range 2..32
// PORTS
//  clk     in   1      system clock, rising edge
//  rst_n   in   1      asynchronous, active-low reset
//  start   in   1      load request; sampled only in IDLE
//  a       in   WIDTH  operand A; sampled with start
//  b       in   WIDTH  operand B; sampled with start
//  cin     in   1      carry-in; sampled with start
//  sub     in   1      subtract select; sampled with start (present only with SERIAL_ADDSUB_EN)
//  busy    out  1      high while bits are being processed
//  done    out  1      one-cycle pulse: sum/cout valid and updated
//  sum     out  WIDTH  registered result; holds until the next completion
//  cout    out  1      registered final carry; holds until the next completion
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sum=0, cout=0; shift regs, carry FF, counter=0.
//  FSM: IDLE -> RUN on start=1; RUN -> IDLE after WIDTH bit cycles. No other states.
//  IDLE, start=1 at edge E0: a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, busy<=1.
//  RUN, each edge: fa_cell(a_sr[0], b_sr[0], carry) -> (s, c).
//    a_sr, b_sr shift right; s shifts into sum_sr MSB; carry<=c; cnt<=cnt+1.
//  Edge E0+WIDTH (last bit): sum<=final sum_sr incl. last s; cout<=c; done<=1; busy<=0; state<=IDLE.
//  Latency: done is high in the cycle after edge E0+WIDTH. busy is high for exactly WIDTH cycles.
//  done is deasserted at the following edge. done is never high on two consecutive cycles.
//  start while busy: ignored. Operands are not re-sampled and the in-flight result is not disturbed.
//  start in the cycle done is high: accepted (state is IDLE). Back-to-back throughput is 1 op per WIDTH+1 cycles.
//  Width rules: sum is modulo 2^WIDTH; cout is bit WIDTH of a+b+cin. No overflow flag.
//  cnt width is $clog2(WIDTH+1). cnt never wraps: it is cleared on every load.
//  Reset mid-RUN: immediate return to reset values; the partial result is discarded and done never pulses.
// CONFIGURATION
//  SERIAL_ADDSUB_EN defined:
//    - sub port exists. On load: b_sr<=b^{WIDTH{sub}}, carry<=cin^sub.
//    - sub=1 with cin=0 gives sum = a-b (two's complement); cout=1 means no borrow.
//  SERIAL_ADDSUB_EN undefined:
//    - no sub port; add only; no inverter logic is synthesised.
// STRUCTURE
//  Shared package dlcd_pkg:
//    - state encoding localparams ST_IDLE=1'b0, ST_RUN=1'b1
//    - DLCD_MAX_WIDTH=32, used for the parameter range check
//  Sub-module fa_cell (a, b, c -> sum, carry):
//    - purely combinational 1-bit full adder; one instance.
//  Top level holds the FSM, three WIDTH-bit shift registers, the carry FF, the counter and the output registers.
// TESTING (WIDTH=4 unless noted)
//  1. a=0101, b=0011, cin=0, start 1 cycle
//       -> busy high 4 cycles; done pulse 4 edges after the load edge; sum=1000, cout=0.
//  2. a=1111, b=0001, cin=0 -> sum=0000, cout=1 (wrap). Then a=1111, b=1111, cin=1 -> sum=1111, cout=1.
//  3. Exhaustive sweep of a, b, cin (512 ops), back-to-back with start in each done cycle
//       -> every result equals {cout,sum}=a+b+cin; 5 cycles per op.
//  4. Load a=0001, b=0001; during RUN pulse start with a=1111, b=1111
//       -> result sum=0010, cout=0; no extra done.
//  5. rst_n low 2 cycles into RUN, asynchronous to clk
//       -> busy/done/sum/cout are 0 before the next edge; a fresh op after release gives the correct result.
//  6. SERIAL_ADDSUB_EN, sub=1, cin=0:
//       a=0111, b=0010 -> sum=0101, cout=1
//       a=0010, b=0111 -> sum=1011, cout=0

Source files
------------

// File: rtl/dlcd_pkg.sv
// Shared definitions for the bit-serial datapath blocks: FSM state encoding and width limits.
package dlcd_pkg;
   localparam logic ST_IDLE        = 1'b0;
   localparam logic ST_RUN         = 1'b1;
   localparam int   DLCD_MAX_WIDTH = 32;

   typedef enum logic {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN
   } state_t;
endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder, purely combinational; the one arithmetic cell the serial adder reuses every bit.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: loads on start, adds one bit per clock LSB first, done pulses one cycle after the last bit.
// Optional subtract mode (sub port, inverted B and carry-in) is compiled in with SERIAL_ADDSUB_EN.
module serial_adder
   import dlcd_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDSUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   if (WIDTH < 2 || WIDTH > DLCD_MAX_WIDTH) begin : g_bad_width
      $error("serial_adder: WIDTH out of range");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             done_q, done_d;
   logic             fa_s, fa_c;
   logic             load_inv;

`ifdef SERIAL_ADDSUB_EN
   assign load_inv = sub;
`else
   assign load_inv = 1'b0;
`endif

   fa_cell u_fa (
      .a     (a_sr_q[0]),
      .b     (b_sr_q[0]),
      .c     (carry_q),
      .sum   (fa_s),
      .carry (fa_c)
   );

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      done_d   = 1'b0;
      if (state_q == S_IDLE) begin
         if (start) begin
            a_sr_d  = a;
            b_sr_d  = b ^ {WIDTH{load_inv}};
            carry_d = cin ^ load_inv;
            cnt_d   = '0;
            state_d = S_RUN;
         end
      end else begin
         a_sr_d   = a_sr_q >> 1;
         b_sr_d   = b_sr_q >> 1;
         sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
         carry_d  = fa_c;
         cnt_d    = cnt_q + CW'(1);
         // After WIDTH shifts the first sum bit has reached the LSB.
         if (cnt_q == CNT_LAST) begin
            sum_d   = sum_sr_d;
            cout_d  = fa_c;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         done_q   <= done_d;
      end
   end

   // The oldest sum bit falls off the end of the shift register and is never needed.
   logic unused_sum_lsb;
   assign unused_sum_lsb = sum_sr_q[0];

   assign busy = (state_q == S_RUN);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
endmodule
